seg7_pattern_decoder: RTL

//  Inverse of the team's hex-to-7-segment encoder: samples an active-low gfedcba segment bus, filters

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_pattern_decoder_settle_filter.sv | 47 ++++
 rtl/seg7_pattern_decoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared encodings for the 7-segment pattern decoder: result kinds and active-low gfedcba glyphs.
// Glyphs A-F are only decoded when SEG7DEC_HEX_EN is defined (see seg7_pattern_decoder).
package seg7_pkg;

  typedef enum logic [1:0] {
    KIND_DIGIT   = 2'd0,
    KIND_DASH    = 2'd1,
    KIND_BLANK   = 2'd2,
    KIND_INVALID = 2'd3
  } kind_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [7:0] HEX_INVALID = 8'hFF;

endpackage

// File: rtl/seg7_pattern_decoder_settle_filter.sv
// Synchronizes the asynchronous segment bus and pulses `settled` once when a pattern has been
// seen on STABLE_CYCLES consecutive synchronized samples.
module seg7_settle_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg7,
  output logic       settled,
  output logic [6:0] pattern
);
  import seg7_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       sync_m, sync_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             changed;

  assign changed = (sync_q != prev_q);

  always_comb begin
    cnt_n = cnt_q;
    if (changed)              cnt_n = '0;
    else if (cnt_q != CNT_MAX) cnt_n = cnt_q + 1'b1;
  end

  // Pulse on the cycle the count arrives at the limit; with STABLE_CYCLES=1 that is the change itself.
  assign settled = (cnt_n == CNT_MAX) && (changed || (cnt_q != CNT_MAX));
  assign pattern = sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_m <= SEG_BLANK;
      sync_q <= SEG_BLANK;
      prev_q <= SEG_BLANK;
      cnt_q  <= '0;
    end else begin
      sync_m <= seg7;
      sync_q <= sync_m;
      prev_q <= sync_q;
      cnt_q  <= cnt_n;
    end
  end

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Decodes settled active-low segment patterns to hex/kind and offers them over valid/ready.
// Define SEG7DEC_HEX_EN to also decode the A-F glyphs as digits 8'h0A..8'h0F.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg7,
  output logic [7:0] hex,
  output logic [1:0] kind,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  input  logic       clr_ovr
);
  import seg7_pkg::*;

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e     state_q, state_n;
  logic       settled, accept, load, drop;
  logic [6:0] pattern, last_q;
  logic [7:0] hex_q, dec_hex;
  kind_e      kind_q, dec_kind;

  seg7_settle_filter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_filter (
    .clock  (clock),
    .reset  (reset),
    .seg7   (seg7),
    .settled(settled),
    .pattern(pattern)
  );

  always_comb begin
    dec_hex  = 8'h00;
    dec_kind = KIND_DIGIT;
    case (pattern)
      SEG_0: dec_hex = 8'h00;
      SEG_1: dec_hex = 8'h01;
      SEG_2: dec_hex = 8'h02;
      SEG_3: dec_hex = 8'h03;
      SEG_4: dec_hex = 8'h04;
      SEG_5: dec_hex = 8'h05;
      SEG_6: dec_hex = 8'h06;
      SEG_7: dec_hex = 8'h07;
      SEG_8: dec_hex = 8'h08;
      SEG_9: dec_hex = 8'h09;
`ifdef SEG7DEC_HEX_EN
      SEG_A: dec_hex = 8'h0A;
      SEG_B: dec_hex = 8'h0B;
      SEG_C: dec_hex = 8'h0C;
      SEG_D: dec_hex = 8'h0D;
      SEG_E: dec_hex = 8'h0E;
      SEG_F: dec_hex = 8'h0F;
`endif
      SEG_DASH:  dec_kind = KIND_DASH;
      SEG_BLANK: dec_kind = KIND_BLANK;
      default: begin
        dec_hex  = HEX_INVALID;
        dec_kind = KIND_INVALID;
      end
    endcase
  end

  // Only a fresh pattern counts; re-settling onto the last accepted one is silent.
  assign accept = settled && (pattern != last_q);

  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      ST_EMPTY: if (accept) begin
        load    = 1'b1;
        state_n = ST_FULL;
      end
      ST_FULL: begin
        if (accept && out_ready) load = 1'b1;
        else if (accept)         drop = 1'b1;
        else if (out_ready)      state_n = ST_EMPTY;
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      hex_q   <= 8'h00;
      kind_q  <= KIND_BLANK;
      last_q  <= SEG_BLANK;
      overrun <= 1'b0;
    end else begin
      state_q <= state_n;
      if (accept) last_q <= pattern;
      if (load) begin
        hex_q  <= dec_hex;
        kind_q <= dec_kind;
      end
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  assign hex       = hex_q;
  assign kind      = kind_q;
  assign out_valid = (state_q == ST_FULL);

endmodule
